// File: rtl/l2_mem_responder.sv
// Single-ported 128-bit line store serving the L2 I/D refill ports; ready pulses LATENCY cycles after accept.
// Ungranted requests simply wait; MEM_RR_ARB_EN selects round-robin arbitration instead of D-port priority.
module l2_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 8
) (
  input  logic         clk,
  input  logic         proc_reset_n,
  input  logic         memi_read,
  input  logic         memi_write,
  input  logic [27:0]  memi_addr,
  input  logic [127:0] memi_wdata,
  output logic [127:0] memi_rdata,
  output logic         memi_ready,
  input  logic         memd_read,
  input  logic         memd_write,
  input  logic [27:0]  memd_addr,
  input  logic [127:0] memd_wdata,
  output logic [127:0] memd_rdata,
  output logic         memd_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [7:0] LOAD_CNT = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

  state_t                  state, state_nxt;
  logic [7:0]              cnt, cnt_nxt;
  logic                    armed;
  logic                    req_i, req_d, req_any, grant_d;
  logic                    sel_write;
  logic [DEPTH_LOG2-1:0]   sel_idx;
  logic [127:0]            sel_wdata;
  logic                    cap_write, cap_port_d;
  logic [DEPTH_LOG2-1:0]   cap_idx;
  logic [127:0]            cap_wdata;
  logic                    cur_write, cur_port_d;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [127:0]            cur_wdata;
  logic                    enter_resp;
  logic [127:0]            mem [2**DEPTH_LOG2];
  logic                    unused_addr_bits;

  assign unused_addr_bits = &{1'b0, memi_addr[27:DEPTH_LOG2], memd_addr[27:DEPTH_LOG2]};

  assign req_i = memi_read | memi_write;
  assign req_d = memd_read | memd_write;
  // Acceptance waits for the first edge after reset release, so no array write can land while reset is held.
  assign req_any = armed & (req_i | req_d);

`ifdef MEM_RR_ARB_EN
  logic rr_prefer_d;

  assign grant_d = req_d & (~req_i | rr_prefer_d);

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      rr_prefer_d <= 1'b0;
    end else if (state == IDLE && req_any) begin
      rr_prefer_d <= ~grant_d;
    end
  end
`else
  assign grant_d = req_d;
`endif

  // A port raising both read and write is treated as a write.
  assign sel_write = grant_d ? memd_write : memi_write;
  assign sel_idx   = grant_d ? memd_addr[DEPTH_LOG2-1:0] : memi_addr[DEPTH_LOG2-1:0];
  assign sel_wdata = grant_d ? memd_wdata : memi_wdata;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    cur_write  = cap_write;
    cur_port_d = cap_port_d;
    cur_idx    = cap_idx;
    cur_wdata  = cap_wdata;
    case (state)
      IDLE: begin
        if (req_any) begin
          cur_write  = sel_write;
          cur_port_d = grant_d;
          cur_idx    = sel_idx;
          cur_wdata  = sel_wdata;
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = LOAD_CNT;
          end
        end
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      cap_write  <= 1'b0;
      cap_port_d <= 1'b0;
      cap_idx    <= '0;
      cap_wdata  <= '0;
    end else if (state == IDLE && req_any) begin
      cap_write  <= sel_write;
      cap_port_d <= grant_d;
      cap_idx    <= sel_idx;
      cap_wdata  <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && cur_write) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      memi_ready <= 1'b0;
      memd_ready <= 1'b0;
      memi_rdata <= '0;
      memd_rdata <= '0;
    end else begin
      memi_ready <= enter_resp & ~cur_port_d;
      memd_ready <= enter_resp & cur_port_d;
      if (enter_resp && !cur_write && !cur_port_d) memi_rdata <= mem[cur_idx];
      if (enter_resp && !cur_write && cur_port_d)  memd_rdata <= mem[cur_idx];
    end
  end
endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: two instances (LATENCY 8 and 1) checked against a cycle-count transaction model.
module tb_l2_mem_responder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         memi_read [2], memi_write [2], memd_read [2], memd_write [2];
  logic [27:0]  memi_addr [2], memd_addr [2];
  logic [127:0] memi_wdata [2], memd_wdata [2], memi_rdata [2], memd_rdata [2];
  logic         memi_ready [2], memd_ready [2];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  bit           cmp_on = 1'b0;

  localparam logic [127:0] D1 = 128'h0000_0000_0000_0000_0000_0000_0000_A5A5;
  localparam logic [127:0] D2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_0F0F;
  localparam logic [127:0] D3 = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    l2_mem_responder #(.DEPTH_LOG2(10), .LATENCY(g == 0 ? 8 : 1)) dut (
      .clk(clk), .proc_reset_n(rst_n),
      .memi_read(memi_read[g]), .memi_write(memi_write[g]), .memi_addr(memi_addr[g]),
      .memi_wdata(memi_wdata[g]), .memi_rdata(memi_rdata[g]), .memi_ready(memi_ready[g]),
      .memd_read(memd_read[g]), .memd_write(memd_write[g]), .memd_addr(memd_addr[g]),
      .memd_wdata(memd_wdata[g]), .memd_rdata(memd_rdata[g]), .memd_ready(memd_ready[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 8 : 1;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: a grant at cycle t owns the store through cycle t+LATENCY and completes at its start.
  bit           busy [2], last_d [2], mport [2], mwr [2];
  int           due [2], midx [2];
  logic [127:0] mwd [2];
  logic [127:0] mm [2][1024];
  logic         exp_ri [2], exp_rd [2];
  logic [127:0] exp_di [2], exp_dd [2];

  always @(posedge clk or negedge rst_n) begin
    bit ri, rd, d;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        busy[k] = 1'b0; last_d[k] = 1'b1; due[k] = 0;
        exp_ri[k] = 1'b0; exp_rd[k] = 1'b0; exp_di[k] = '0; exp_dd[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_ri[k] = 1'b0;
        exp_rd[k] = 1'b0;
        ri = memi_read[k] | memi_write[k];
        rd = memd_read[k] | memd_write[k];
        if ((!busy[k] || cyc > due[k]) && (ri || rd)) begin
          if (ri && rd) begin
`ifdef MEM_RR_ARB_EN
            d = ~last_d[k];
`else
            d = 1'b1;
`endif
          end else begin
            d = rd;
          end
          last_d[k] = d;
          busy[k]   = 1'b1;
          due[k]    = cyc + lat_of(k);
          mport[k]  = d;
          mwr[k]    = d ? memd_write[k] : memi_write[k];
          midx[k]   = int'(d ? memd_addr[k][9:0] : memi_addr[k][9:0]);
          mwd[k]    = d ? memd_wdata[k] : memi_wdata[k];
        end
        if (busy[k] && due[k] == cyc + 1) begin
          if (mwr[k]) mm[k][midx[k]] = mwd[k];
          else if (mport[k]) exp_dd[k] = mm[k][midx[k]];
          else exp_di[k] = mm[k][midx[k]];
          if (mport[k]) exp_rd[k] = 1'b1;
          else exp_ri[k] = 1'b1;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("k%0d memi_ready c%0d", k, cyc), memi_ready[k], exp_ri[k]);
        chk($sformatf("k%0d memd_ready c%0d", k, cyc), memd_ready[k], exp_rd[k]);
        chk($sformatf("k%0d memi_rdata c%0d", k, cyc), memi_rdata[k], exp_di[k]);
        chk($sformatf("k%0d memd_rdata c%0d", k, cyc), memd_rdata[k], exp_dd[k]);
      end
    end
  end

  task automatic set_req(int k, bit dp, bit rd, bit wr, logic [27:0] a, logic [127:0] d);
    if (dp) begin
      memd_read[k] = rd; memd_write[k] = wr; memd_addr[k] = a; memd_wdata[k] = d;
    end else begin
      memi_read[k] = rd; memi_write[k] = wr; memi_addr[k] = a; memi_wdata[k] = d;
    end
  endtask

  task automatic next_slot;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int k, output int port, output int at);
    port = -1;
    at   = -1;
    for (int n = 0; n < 64 && port < 0; n++) begin
      @(negedge clk);
      if (memi_ready[k]) begin port = 0; at = cyc; end
      else if (memd_ready[k]) begin port = 1; at = cyc; end
    end
    if (port < 0) begin
      checks++;
      errors++;
      $display("FAIL k%0d ready timeout: got no pulse in 64 cycles, required one", k);
    end
  endtask

  initial begin
    int t0, p, at, p2, at2, first_exp, pulses;
    for (int k = 0; k < 2; k++) begin
      set_req(k, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(k, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset memd_rdata", memd_rdata[0], '0);
    chk("reset memi_ready", memi_ready[0], '0);
    repeat (2) next_slot;

    // Writeback then allocate on the D-port, same address, read raised the cycle after ready.
    next_slot;
    t0 = cyc;
    set_req(0, 1'b1, 1'b0, 1'b1, 28'h0000010, D1);
    wait_rdy(0, p, at);
    chk("wb ready cycle", at - t0, 8);
    chk("wb ready port", p, 1);
    next_slot;
    set_req(0, 1'b1, 1'b1, 1'b0, 28'h0000010, '0);
    wait_rdy(0, p, at);
    chk("alloc ready cycle", at - t0, 17);
    chk("alloc rdata", memd_rdata[0], D1);
    next_slot;
    set_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("alloc rdata held c18", memd_rdata[0], D1);
    chk("alloc ready low c18", memd_ready[0], 1'b0);

    // LATENCY=1: preload line 3 through the I-port, then read it back.
    next_slot;
    set_req(1, 1'b0, 1'b0, 1'b1, 28'h3, 128'h1234);
    wait_rdy(1, p, at);
    next_slot;
    t0 = cyc;
    set_req(1, 1'b0, 1'b1, 1'b0, 28'h3, '0);
    wait_rdy(1, p, at);
    chk("lat1 read latency", at - t0, 1);
    chk("lat1 read port", p, 0);
    chk("lat1 rdata", memi_rdata[1], 128'h1234);
    next_slot;
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("lat1 pulse width", memi_ready[1], 1'b0);

    // Simultaneous reads on both ports.
    next_slot;
    set_req(0, 1'b1, 1'b0, 1'b1, 28'h0000020, D2);
    wait_rdy(0, p, at);
    next_slot;
    set_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
    next_slot;
`ifdef MEM_RR_ARB_EN
    first_exp = 0;
`else
    first_exp = 1;
`endif
    t0 = cyc;
    set_req(0, 1'b0, 1'b1, 1'b0, 28'h0000010, '0);
    set_req(0, 1'b1, 1'b1, 1'b0, 28'h0000020, '0);
    wait_rdy(0, p, at);
    chk("both first port", p, first_exp);
    chk("both first latency", at - t0, 8);
    next_slot;
    set_req(0, p[0], 1'b0, 1'b0, '0, '0);
    wait_rdy(0, p2, at2);
    chk("both second port", p2, 1 - first_exp);
    chk("both second gap", at2 - at, 9);
    next_slot;
    set_req(0, p2[0], 1'b0, 1'b0, '0, '0);
    chk("both i rdata", memi_rdata[0], D1);
    chk("both d rdata", memd_rdata[0], D2);

    // Upper address bits alias onto the same line.
    next_slot;
    set_req(0, 1'b1, 1'b0, 1'b1, 28'h0000401, D3);
    wait_rdy(0, p, at);
    next_slot;
    set_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b0, 1'b1, 1'b0, 28'h0000001, '0);
    wait_rdy(0, p, at);
    next_slot;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("alias rdata", memi_rdata[0], D3);

    // Reset in the middle of an I-read.
    next_slot;
    set_req(0, 1'b0, 1'b1, 1'b0, 28'h0000020, '0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst memi_ready", memi_ready[0], 1'b0);
    chk("rst memi_rdata", memi_rdata[0], '0);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (memi_ready[0] || memd_ready[0]) pulses++;
    end
    chk("no spurious ready", pulses, 0);

    // Request held through RESP and beyond: one pulse per acceptance, LATENCY+1 apart.
    for (int k = 0; k < 2; k++) begin
      next_slot;
      t0 = cyc;
      set_req(k, 1'b0, 1'b1, 1'b0, (k == 0) ? 28'h0000010 : 28'h3, '0);
      wait_rdy(k, p, at);
      chk($sformatf("k%0d held first latency", k), at - t0, lat_of(k));
      wait_rdy(k, p2, at2);
      chk($sformatf("k%0d held second gap", k), at2 - at, lat_of(k) + 1);
      next_slot;
      set_req(k, 1'b0, 1'b0, 1'b0, '0, '0);
    end

    repeat (4) next_slot;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Main-memory model and responder for the L2 cache's two refill ports: it answers the instruction-side (`memi_*`) and data-side (`memd_*`) read/write requests issued by the L2 cache. Both ports share one single-ported backing store of 128-bit lines. Each accepted request completes after a fixed, parameterised latency with a one-cycle ready pulse. The block sits between the L2 cache and the top-level testbench/SoC boundary and stands in for DRAM.

## Interface
- `DEPTH_LOG2`, 10, log2 of backing-store depth in 128-bit lines; line index = `addr[DEPTH_LOG2-1:0]`, upper address bits ignored
- `LATENCY`, 8, cycles from request acceptance to ready pulse; legal range 1..255
- `clk`  in  1  single clock, all state on rising edge
- `proc_reset_n`  in  1  asynchronous, active-low reset
- `memi_read`  in  1  I-port line read request, held until `memi_ready`
- `memi_write`  in  1  I-port line write request, held until `memi_ready`
- `memi_addr`  in  28  I-port line address
- `memi_wdata`  in  128  I-port write line
- `memi_rdata`  out  128  I-port read line, registered
- `memi_ready`  out  1  I-port completion pulse
- `memd_read`, `memd_write`, `memd_addr`, `memd_wdata`, `memd_rdata`, `memd_ready`  same as I-port, for the D-port

## Operation
- Reset values: `memi_ready`=0, `memd_ready`=0, `memi_rdata`=0, `memd_rdata`=0, FSM=IDLE, counter=0, round-robin pointer=I. Storage array is not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE: a port is requesting when its read or write is high. Grant one requesting port and capture its op, address, wdata and port ID. Go to RESP if `LATENCY`==1; otherwise load counter with `LATENCY`-2 and go to BUSY.
- BUSY: decrement the counter each cycle. At 0, go to RESP.
- RESP: one cycle. Raise ready on the owning port only, then return to IDLE.
- Read and write both high on one port: treat as a write; the read flag is ignored.
- Captured transaction completes even if the requester drops its request early. No abort.
- Write commits `wdata` to `mem[addr]` on the edge entering RESP.
- Read loads the owning port's `rdata` from `mem[addr]` on the edge entering RESP. `rdata` then holds until that port's next read completes. Writes never change `rdata`.
- Requests are never accepted in BUSY or RESP. The requester's still-high request during the RESP cycle must not be re-accepted.
- A write followed by a read to the same address on either port returns the written data.

## Timing
- Request high in IDLE cycle t and granted → ready high in cycle t+`LATENCY`, for exactly one cycle.
- Earliest next acceptance: cycle t+`LATENCY`+1, giving back-to-back turnaround `LATENCY`+1.
- This supports the cache's D-side writeback→allocate sequence: write drops and read rises with the same address in the cycle after ready.
- `rdata` is valid in the ready cycle and in every following cycle until the next read completion on that port. The cache samples it the cycle after ready.
- Ungranted requests wait with no timeout. At most one transaction is in flight.
- `proc_reset_n` low at any time, including mid-transaction: outputs and FSM clear asynchronously. The in-flight write may or may not have committed only if reset arrives on the RESP edge; otherwise it has not.

## Configuration
- `MEM_RR_ARB_EN` defined: round-robin arbitration. When both ports request in IDLE, grant the port not granted last. The pointer updates on every grant.
- `MEM_RR_ARB_EN` undefined: fixed priority. The D-port wins whenever both request; the pointer is unused.
- Single-requester behaviour and all timing are identical in both builds.

## Test plan
- Reset, `LATENCY`=8: D-write addr 0x0000010, data 0x…A5A5. Then, on the cycle after ready, D-read addr 0x0000010 → first ready at cycle 8, second at cycle 17, `memd_rdata`=0x…A5A5 held through cycle 18.
- `LATENCY`=1: I-read addr 0x3 after preloading mem[3]=0x1234 → `memi_ready` one cycle after request, pulse width 1, `memd_ready` stays 0.
- Both ports read simultaneously. With `MEM_RR_ARB_EN`: I served first (pointer reset=I), D ready `LATENCY`+1 cycles later. Without it: D first, then I.
- Aliasing, `DEPTH_LOG2`=10: write addr 0x0000401, read addr 0x0000001 → returns written data.
- Assert `proc_reset_n` low during BUSY of an I-read → `memi_ready`/`memi_rdata` go 0 immediately; after release, no spurious ready until a new request.
- Request held high through RESP and the following cycle: exactly one ready pulse per accepted request, and a second pulse only `LATENCY`+1 cycles later.
